qupls_decode_sequencer: RTL and testbench
=========================================

Name: qupls_decode_sequencer

Overview:
- Front-end controller that owns the registered instruction decoder.
- Buffers fetched instruction words in a small FIFO and presents a 6-slot window to the decoder (head instruction plus up to 5 following postfix/immediate words).
- Asserts the decoder enable only when the whole head instruction is present and the decoded-bus register is free.
- Consumes REX prefixes itself, applying the extended-register bits to the next decoded instruction.

Parameters:
- DEPTH, 8: FIFO entries, power of two, ≥ WIN.
- WIN, 6: window slots presented to the decoder; fixed by the decoder port.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush (branch miss/exception)
- push_i  in  1  fetch writes one instruction word
- push_ins_i  in  instruction_t  word to enqueue
- full_o  out  1  FIFO full; a push while full is dropped
- count_o  out  $clog2(DEPTH+1)  occupied entries
- win_o  out  instruction_t[WIN-1:0]  decoder instr window, slot 0 = head
- len_i  in  3  head instruction length in words (1..6), combinational from win_o
- is_rex_i  in  1  head word is a REX prefix, combinational from win_o
- rex_regx_i  in  4  REX register-extension bits of head
- dec_en_o  out  1  decoder register enable (combinational)
- dec_regx_o  out  4  regx presented to decoder
- dbo_valid_o  out  1  decoder output register holds a valid bundle
- dbo_ready_i  in  1  downstream accepts bundle this cycle
- state_o  out  2  debug: 0 EMPTY, 1 FILL, 2 RUN, 3 HOLD

Behaviour:
- Reset: FIFO cleared (rd/wr ptr 0, count_o 0); full_o, dec_en_o, dbo_valid_o, rex_pend 0; dec_regx_o 0; state_o EMPTY.
- Window:
  - win_o[i] = FIFO[rd_ptr+i] (modulo DEPTH) when i < count_o; otherwise all-zero.
  - Pointer wrap is modulo DEPTH.
- free = !dbo_valid_o | dbo_ready_i.
- REX consume:
  - Condition: count_o ≥ 1, is_rex_i, !flush_i.
  - Action: pop 1; rex_reg ← rex_regx_i; rex_pend ← 1; dec_en_o stays 0.
  - Back-to-back REX: the last one wins.
  - REX consumption does not depend on free.
- Issue:
  - Condition: !is_rex_i, count_o ≥ len_i, len_i ≠ 0, free, !flush_i.
  - dec_en_o = 1 combinationally. At the edge: pop len_i words; dbo_valid_o ← 1; rex_pend ← 0.
  - dec_regx_o = rex_pend ? rex_reg : 0.
  - Decoder latency: bundle is visible 1 cycle after dec_en_o.
- dbo_valid_o:
  - Cleared at the edge where dbo_ready_i=1 and no issue occurs.
  - Held when !dbo_ready_i. The decoder register also holds because dec_en_o=0.
- Simultaneous push and pop: count_o += push_accepted − popped. A word pushed this cycle is not visible in win_o until the next cycle.
- full_o = (count_o == DEPTH). A push when full with a simultaneous pop is still dropped (decision based on registered count).
- len_i > count_o: FILL, no issue; wait for more words.
- flush_i (priority over all):
  - At the edge: pointers and count zeroed; rex_pend 0; dbo_valid_o 0.
  - A push in the same cycle is discarded; dec_en_o forced 0.
  - Reset mid-operation behaves identically to flush plus perf counter clear.
- state_o (registered, from next-state):
  - EMPTY: count 0.
  - FILL: count>0 and head incomplete.
  - HOLD: head complete but !free.
  - RUN: otherwise.

Optional Feature:
- QUPLS_DECSEQ_PERF_EN defined: adds outputs starve_cnt_o[31:0] and bkpr_cnt_o[31:0].
  - starve_cnt_o increments each cycle in EMPTY or FILL with !flush_i.
  - bkpr_cnt_o increments each cycle in HOLD.
  - Both saturate at 32'hFFFFFFFF and clear on rst only (not on flush).
- Undefined: ports absent, no counter logic.

Test Plan:
- Reset then push 3 words, len_i=1 each, dbo_ready_i=1 → dec_en_o high on 3 consecutive cycles starting the cycle after the first push; dbo_valid_o high for 3 cycles; count_o returns to 0.
- Push 2 words, len_i=4 → FILL, dec_en_o=0, win_o[2..5]=0. Push 2 more → dec_en_o=1 next cycle; pop 4; count_o=0.
- Head is REX with rex_regx_i=4'b1010, followed by a len 1 instruction → REX popped with no dec_en_o. Next cycle dec_en_o=1 with dec_regx_o=4'b1010; the following instruction gets dec_regx_o=0.
- Issue with dbo_ready_i=0 for 3 cycles → dbo_valid_o stays 1, dec_en_o=0, state_o=HOLD. Raise ready → issue of the next instruction in the same cycle, dbo_valid_o stays 1.
- Fill to 8 and push a 9th word → full_o=1, word dropped. Then flush_i together with a push → count_o=0, dbo_valid_o=0, rex_pend cleared, next-cycle state EMPTY.
- With QUPLS_DECSEQ_PERF_EN: 5 empty cycles then 2 HOLD cycles → starve_cnt_o=5, bkpr_cnt_o=2; flush leaves both unchanged.

Source files
------------

// File: rtl/qupls_decode_sequencer.sv
// Decode front-end: instruction FIFO, 6-slot decoder window, issue/REX control.
// Optional perf counters under `QUPLS_DECSEQ_PERF_EN`. Instruction words are InsW bits wide.
module qupls_decode_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIN   = 6,
    parameter int unsigned InsW  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [InsW-1:0]               push_ins_i,
    output logic                          full_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic [WIN-1:0][InsW-1:0]      win_o,
    input  logic [2:0]                    len_i,
    input  logic                          is_rex_i,
    input  logic [3:0]                    rex_regx_i,
    output logic                          dec_en_o,
    output logic [3:0]                    dec_regx_o,
    output logic                          dbo_valid_o,
    input  logic                          dbo_ready_i,
`ifdef QUPLS_DECSEQ_PERF_EN
    output logic [31:0]                   starve_cnt_o,
    output logic [31:0]                   bkpr_cnt_o,
`endif
    output logic [1:0]                    state_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFill  = 2'd1,
        StRun   = 2'd2,
        StHold  = 2'd3
    } state_e;

    logic [InsW-1:0] mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d, pop_cnt;
    logic            dbo_valid_q, dbo_valid_d;
    logic            rex_pend_q, rex_pend_d;
    logic [3:0]      rex_reg_q, rex_reg_d;
    state_e          state_q, state_d;

    logic full, free, rex_take, head_ok, issue, push_ok;

    // Slots beyond the occupied count read as zero so the decoder never sees stale words.
    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            win_o[i] = '0;
            if (CW'(i) < count_q) begin
                win_o[i] = mem_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        free     = !dbo_valid_q || dbo_ready_i;
        rex_take = (count_q != '0) && is_rex_i && !flush_i;
        head_ok  = (count_q != '0) &&
                   (is_rex_i || ((len_i != 3'd0) && (count_q >= CW'(len_i))));
        issue    = !is_rex_i && (len_i != 3'd0) && (count_q >= CW'(len_i)) && free && !flush_i;
        push_ok  = push_i && !full && !flush_i;
        pop_cnt  = rex_take ? CW'(1) : (issue ? CW'(len_i) : '0);

        count_d     = count_q + CW'(push_ok) - pop_cnt;
        rd_ptr_d    = rd_ptr_q + pop_cnt[PW-1:0];
        wr_ptr_d    = wr_ptr_q + PW'(push_ok);
        dbo_valid_d = dbo_valid_q;
        rex_pend_d  = rex_pend_q;
        rex_reg_d   = rex_reg_q;

        if (issue) begin
            dbo_valid_d = 1'b1;
        end else if (dbo_ready_i) begin
            dbo_valid_d = 1'b0;
        end

        // A REX prefix only tags the next issued instruction; the last prefix wins.
        if (rex_take) begin
            rex_pend_d = 1'b1;
            rex_reg_d  = rex_regx_i;
        end else if (issue) begin
            rex_pend_d = 1'b0;
        end

        if (flush_i || (count_q == '0)) begin
            state_d = StEmpty;
        end else if (!head_ok) begin
            state_d = StFill;
        end else if (!free) begin
            state_d = StHold;
        end else begin
            state_d = StRun;
        end

        if (flush_i) begin
            count_d     = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            dbo_valid_d = 1'b0;
            rex_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_ins_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            dbo_valid_q <= 1'b0;
            rex_pend_q  <= 1'b0;
            rex_reg_q   <= '0;
            state_q     <= StEmpty;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            dbo_valid_q <= dbo_valid_d;
            rex_pend_q  <= rex_pend_d;
            rex_reg_q   <= rex_reg_d;
            state_q     <= state_d;
        end
    end

`ifdef QUPLS_DECSEQ_PERF_EN
    logic [31:0] starve_q, bkpr_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            bkpr_q   <= '0;
        end else begin
            if ((state_q == StEmpty || state_q == StFill) && !flush_i && (starve_q != '1)) begin
                starve_q <= starve_q + 32'd1;
            end
            if ((state_q == StHold) && (bkpr_q != '1)) begin
                bkpr_q <= bkpr_q + 32'd1;
            end
        end
    end

    assign starve_cnt_o = starve_q;
    assign bkpr_cnt_o   = bkpr_q;
`endif

    assign full_o      = full;
    assign count_o     = count_q;
    assign dec_en_o    = issue;
    assign dec_regx_o  = rex_pend_q ? rex_reg_q : 4'd0;
    assign dbo_valid_o = dbo_valid_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_qupls_decode_sequencer.sv
// Table-driven bench for qupls_decode_sequencer; a tiny decoder model derives len/REX from win_o[0].
// Perf-counter sequence runs only when QUPLS_DECSEQ_PERF_EN is defined.
module tb_qupls_decode_sequencer;

    localparam logic [1:0] SE = 2'd0, SF = 2'd1, SR = 2'd2, SH = 2'd3;

    localparam logic [31:0] A1 = 32'h0000_1011, A2 = 32'h0000_1021, A3 = 32'h0000_1031;
    localparam logic [31:0] B0 = 32'h0000_2004, B1 = 32'h0000_2100;
    localparam logic [31:0] B2 = 32'h0000_2200, B3 = 32'h0000_2300;
    localparam logic [31:0] RX = 32'h8000_00A1;
    localparam logic [31:0] C1 = 32'h0000_3011, C2 = 32'h0000_3021;
    localparam logic [31:0] D1 = 32'h0000_4011, D2 = 32'h0000_4021, D3 = 32'h0000_4031;
    localparam logic [31:0] E0 = 32'h0000_5000, E8 = 32'h0000_5800;
    localparam logic [31:0] FF = 32'h0000_7001, GG = 32'h0000_6000, XX = 32'hDEAD_0008;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush_i = 1'b0;
    logic             push_i = 1'b0;
    logic [31:0]      push_ins_i = '0;
    logic             full_o;
    logic [3:0]       count_o;
    logic [5:0][31:0] win_o;
    logic [2:0]       len_i;
    logic             is_rex_i;
    logic [3:0]       rex_regx_i;
    logic             dec_en_o;
    logic [3:0]       dec_regx_o;
    logic             dbo_valid_o;
    logic             dbo_ready_i = 1'b0;
    logic [1:0]       state_o;
`ifdef QUPLS_DECSEQ_PERF_EN
    logic [31:0]      starve_cnt_o, bkpr_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    // Decoder model: bit 31 marks REX, bits [7:4] are REX regx, bits [2:0] are length.
    assign len_i      = win_o[0][2:0];
    assign is_rex_i   = win_o[0][31];
    assign rex_regx_i = win_o[0][7:4];

    always #5 clk = ~clk;

    qupls_decode_sequencer #(.DEPTH(8), .WIN(6), .InsW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .push_i      (push_i),
        .push_ins_i  (push_ins_i),
        .full_o      (full_o),
        .count_o     (count_o),
        .win_o       (win_o),
        .len_i       (len_i),
        .is_rex_i    (is_rex_i),
        .rex_regx_i  (rex_regx_i),
        .dec_en_o    (dec_en_o),
        .dec_regx_o  (dec_regx_o),
        .dbo_valid_o (dbo_valid_o),
        .dbo_ready_i (dbo_ready_i),
`ifdef QUPLS_DECSEQ_PERF_EN
        .starve_cnt_o(starve_cnt_o),
        .bkpr_cnt_o  (bkpr_cnt_o),
`endif
        .state_o     (state_o)
    );

    typedef struct {
        logic        push;
        logic [31:0] ins;
        logic        flush;
        logic        ready;
        logic        e_en;
        logic [3:0]  e_cnt;
        logic        e_val;
        logic        e_full;
        logic [1:0]  e_st;
        logic [3:0]  e_regx;
        logic [31:0] e_w0;
        logic        tailz;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic push, input logic [31:0] ins, input logic flush,
                                input logic ready, input logic e_en, input logic [3:0] e_cnt,
                                input logic e_val, input logic e_full, input logic [1:0] e_st,
                                input logic [3:0] e_regx, input logic [31:0] e_w0,
                                input logic tailz);
        vec_t v;
        v.push = push;   v.ins = ins;     v.flush = flush;   v.ready = ready;
        v.e_en = e_en;   v.e_cnt = e_cnt; v.e_val = e_val;   v.e_full = e_full;
        v.e_st = e_st;   v.e_regx = e_regx; v.e_w0 = e_w0;   v.tailz = tailz;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic push, input logic [31:0] ins, input logic flush,
                         input logic ready);
        @(negedge clk);
        push_i      = push;
        push_ins_i  = ins;
        flush_i     = flush;
        dbo_ready_i = ready;
        #2;
    endtask

    initial begin
        // Three len-1 instructions streamed through.
        add(1, A1, 0, 1,  0, 0, 0, 0, SE, 0, 0,  1);
        add(1, A2, 0, 1,  1, 1, 0, 0, SE, 0, A1, 0);
        add(1, A3, 0, 1,  1, 1, 1, 0, SR, 0, A2, 0);
        add(0, 0,  0, 1,  1, 1, 1, 0, SR, 0, A3, 0);
        add(0, 0,  0, 1,  0, 0, 1, 0, SR, 0, 0,  0);
        add(0, 0,  0, 1,  0, 0, 0, 0, SE, 0, 0,  0);
        // Length-4 instruction assembled over several pushes.
        add(1, B0, 0, 1,  0, 0, 0, 0, SE, 0, 0,  0);
        add(1, B1, 0, 1,  0, 1, 0, 0, SE, 0, B0, 1);
        add(0, 0,  0, 1,  0, 2, 0, 0, SF, 0, B0, 1);
        add(1, B2, 0, 1,  0, 2, 0, 0, SF, 0, B0, 1);
        add(1, B3, 0, 1,  0, 3, 0, 0, SF, 0, B0, 0);
        add(0, 0,  0, 1,  1, 4, 0, 0, SF, 0, B0, 0);
        add(0, 0,  0, 1,  0, 0, 1, 0, SR, 0, 0,  0);
        add(0, 0,  0, 1,  0, 0, 0, 0, SE, 0, 0,  0);
        // REX prefix tags only the next instruction.
        add(1, RX, 0, 1,  0, 0, 0, 0, SE, 0,     0,  0);
        add(1, C1, 0, 1,  0, 1, 0, 0, SE, 0,     RX, 0);
        add(1, C2, 0, 1,  1, 1, 0, 0, SR, 4'hA,  C1, 0);
        add(0, 0,  0, 1,  1, 1, 1, 0, SR, 0,     C2, 0);
        add(0, 0,  0, 1,  0, 0, 1, 0, SR, 0,     0,  0);
        add(0, 0,  0, 1,  0, 0, 0, 0, SE, 0,     0,  0);
        // Backpressure: HOLD for three cycles, then issue on ready.
        add(1, D1, 0, 1,  0, 0, 0, 0, SE, 0, 0,  0);
        add(1, D2, 0, 0,  1, 1, 0, 0, SE, 0, D1, 0);
        add(0, 0,  0, 0,  0, 1, 1, 0, SR, 0, D2, 0);
        add(0, 0,  0, 0,  0, 1, 1, 0, SH, 0, D2, 0);
        add(0, 0,  0, 0,  0, 1, 1, 0, SH, 0, D2, 0);
        add(0, 0,  0, 1,  1, 1, 1, 0, SH, 0, D2, 0);
        add(0, 0,  0, 1,  0, 0, 1, 0, SR, 0, 0,  0);
        add(0, 0,  0, 1,  0, 0, 0, 0, SE, 0, 0,  0);
        // Fill to capacity with len-0 words, overflow push, then flush with a push.
        for (int k = 0; k < 8; k++) begin
            add(1, E0 | (32'(k) << 8), 0, 1, 0, 4'(k), 0, 0, (k < 2) ? SE : SF, 0,
                (k == 0) ? 32'h0 : E0, 0);
        end
        add(1, E8, 0, 1,  0, 8, 0, 1, SF, 0, E0, 0);
        add(1, XX, 1, 1,  0, 8, 0, 1, SF, 0, E0, 0);
        // REX consumed under backpressure, then flushed away.
        add(1, D1, 0, 0,  0, 0, 0, 0, SE, 0,    0,  1);
        add(1, RX, 0, 0,  1, 1, 0, 0, SE, 0,    D1, 0);
        add(0, 0,  0, 0,  0, 1, 1, 0, SR, 0,    RX, 0);
        add(1, D2, 0, 0,  0, 0, 1, 0, SH, 4'hA, 0,  0);
        add(0, 0,  1, 0,  0, 1, 1, 0, SE, 4'hA, D2, 0);
        add(1, D3, 0, 1,  0, 0, 0, 0, SE, 0,    0,  0);
        add(0, 0,  0, 1,  1, 1, 0, 0, SE, 0,    D3, 0);
        add(0, 0,  0, 1,  0, 0, 1, 0, SR, 0,    0,  0);
        add(0, 0,  0, 1,  0, 0, 0, 0, SE, 0,    0,  0);

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", -1, 32'(count_o), 32'd0);
        chk("rst_full",  -1, 32'(full_o), 32'd0);
        chk("rst_dec_en", -1, 32'(dec_en_o), 32'd0);
        chk("rst_valid", -1, 32'(dbo_valid_o), 32'd0);
        chk("rst_regx",  -1, 32'(dec_regx_o), 32'd0);
        chk("rst_state", -1, 32'(state_o), 32'(SE));
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].push, vecs[i].ins, vecs[i].flush, vecs[i].ready);
            chk("dec_en",    i, 32'(dec_en_o), 32'(vecs[i].e_en));
            chk("count",     i, 32'(count_o), 32'(vecs[i].e_cnt));
            chk("dbo_valid", i, 32'(dbo_valid_o), 32'(vecs[i].e_val));
            chk("full",      i, 32'(full_o), 32'(vecs[i].e_full));
            chk("state",     i, 32'(state_o), 32'(vecs[i].e_st));
            chk("dec_regx",  i, 32'(dec_regx_o), 32'(vecs[i].e_regx));
            chk("win0",      i, win_o[0], vecs[i].e_w0);
            if (vecs[i].tailz) begin
                chk("win_tail_zero", i, 32'(|win_o[5:2]), 32'd0);
            end
        end

        // Full FIFO with a simultaneous pop: the push is still dropped.
        drive(1, D1, 0, 0);
        drive(1, FF, 0, 0);
        chk("hold_setup_en", 100, 32'(dec_en_o), 32'd1);
        for (int k = 0; k < 7; k++) drive(1, GG, 0, 0);
        drive(1, XX, 0, 1);
        chk("fullpop_full",  101, 32'(full_o), 32'd1);
        chk("fullpop_count", 101, 32'(count_o), 32'd8);
        chk("fullpop_en",    101, 32'(dec_en_o), 32'd1);
        chk("fullpop_state", 101, 32'(state_o), 32'(SH));
        drive(0, 0, 0, 0);
        chk("afterpop_count", 102, 32'(count_o), 32'd7);
        chk("afterpop_full",  102, 32'(full_o), 32'd0);
        chk("afterpop_win0",  102, win_o[0], GG);
        chk("afterpop_valid", 102, 32'(dbo_valid_o), 32'd1);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 1);
        chk("flush2_count", 103, 32'(count_o), 32'd0);
        chk("flush2_valid", 103, 32'(dbo_valid_o), 32'd0);

`ifdef QUPLS_DECSEQ_PERF_EN
        @(negedge clk);
        rst = 1'b1;
        push_i = 1'b0;
        flush_i = 1'b0;
        dbo_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("perf_rst_starve", 200, starve_cnt_o, 32'd0);
        chk("perf_rst_bkpr",   200, bkpr_cnt_o, 32'd0);
        // Reset released at a negedge: the drive below starts the next cycle.
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, D1, 0, 0);
        drive(1, D2, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 1, 1);
        chk("perf_starve", 201, starve_cnt_o, 32'd6);
        chk("perf_bkpr",   201, bkpr_cnt_o, 32'd2);
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        chk("perf_flush_starve", 202, starve_cnt_o, 32'd6);
        chk("perf_flush_bkpr",   202, bkpr_cnt_o, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
